mem_port_arbiter: RTL and testbench

- Shares one synchronous read/write port of the 4 KiW dual-port word memory between two requesters: m0 = CPU load/store unit, m1 = debug/loader.
- Routes each granted read's response back to its owner.
- After reset, an optional sweep clears the whole memory before any grant is issued.
- Sits between the requesters and port 2 of the memory. The memory port clock is tied to clk.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults, FSM state type and requester ids for the memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin on ties unless fixed priority is selected, in which case m0 wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       fixed_prio_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_gnt_q;
    logic last_gnt_d;

    // On a tie the requester that did not win last time is served, so m0 wins the first tie after reset.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (fixed_prio_i || (last_gnt_q == REQ_M1)) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        gnt_id_o   = gnt_o[1] ? REQ_M1 : REQ_M0;
        last_gnt_d = (gnt_o != 2'b00) ? gnt_id_o : last_gnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= REQ_M1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port 2 between the CPU load/store unit (m0) and the debug loader (m1),
// with an optional zero-fill sweep after reset and in-order read response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int BE_W       = BE_W_DEF,
    parameter bit INIT_CLEAR = 1'b1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              init_busy
);

    localparam logic [ADDR_W:0] LAST_ADDR   = {1'b0, {ADDR_W{1'b1}}};
    localparam state_e          RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            rvalid_q, rvalid_d;
    logic            owner_q, owner_d;

    logic [1:0]      gnt;
    logic            gnt_id;
    logic            sel_we;
    logic            arb_en;
    logic            sweep_active;

    // Everything is held quiet while reset is asserted so no grant or response leaks out of a reset cycle.
    assign arb_en       = (state_q == ST_RUN) && !reset;
    assign sweep_active = (state_q == ST_INIT) && !reset;

    rr_arbiter2 u_arb (
        .clk          (clk),
        .reset        (reset),
        .en_i         (arb_en),
        .fixed_prio_i (FIXED_PRIO),
        .req_i        ({m1_req, m0_req}),
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign sel_we = gnt[1] ? m1_we : m0_we;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sweep_active) begin
            mem_we   = 1'b1;
            mem_be   = '1;
            mem_addr = cnt_q[ADDR_W-1:0];
        end else if (gnt[0]) begin
            mem_we    = m0_we;
            mem_be    = m0_be;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt[1]) begin
            mem_we    = m1_we;
            mem_be    = m1_be;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // The counter is one bit wider than the address so the terminal compare cannot wrap back to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
        rvalid_d = (gnt != 2'b00) && !sel_we;
        owner_d  = rvalid_d ? gnt_id : owner_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= REQ_M0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
        end
    end

    assign m0_rvalid = rvalid_q && (owner_q == REQ_M0) && !reset;
    assign m1_rvalid = rvalid_q && (owner_q == REQ_M1) && !reset;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign init_busy = reset ? INIT_CLEAR : (state_q == ST_INIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Runs a round-robin and a fixed-priority arbiter side by side on shared requests, each with its own
// memory, reference model and response scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NI    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          m0_req, m0_we, m1_req, m1_we;
    logic [BW-1:0] m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;

    logic          gnt0 [NI];
    logic          gnt1 [NI];

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam bit FP = (k == 1);

        logic          rv0, rv1, memWe, busy;
        logic [DW-1:0] rd0, rd1, memWd, memRd;
        logic [AW-1:0] memAd;
        logic [BW-1:0] memBe;
        logic [DW-1:0] mem [DEPTH];

        mem_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .INIT_CLEAR(1'b1), .FIXED_PRIO(FP)
        ) dut (
            .clk(clk), .reset(reset),
            .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_gnt(gnt0[k]), .m0_rvalid(rv0), .m0_rdata(rd0),
            .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_gnt(gnt1[k]), .m1_rvalid(rv1), .m1_rdata(rd1),
            .mem_addr(memAd), .mem_be(memBe), .mem_wdata(memWd), .mem_we(memWe),
            .mem_rdata(memRd), .init_busy(busy)
        );

        // Behavioural memory port: byte-enabled write and one-cycle registered read.
        always @(posedge clk) begin
            if (memWe) begin
                for (int b = 0; b < BW; b++) begin
                    if (memBe[b]) mem[memAd][8*b +: 8] <= memWd[8*b +: 8];
                end
            end
            memRd <= mem[memAd];
        end

        logic [DW-1:0] refMem [DEPTH];
        logic          refLast;
        int            refSweep;
        resp_t         expQ[$];
        logic          hasWin, win, wWe;
        logic [BW-1:0] wBe;
        logic [AW-1:0] wAd;
        logic [DW-1:0] wWd;
        logic [63:0]   expDrive, actDrive;

        // Reference model: decides the expected grant and memory drive, then records expected read data.
        always @(negedge clk) begin
            actDrive = 64'({gnt1[k], gnt0[k], busy, memWe, memBe, memAd, memWd});
            if (reset) begin
                expDrive = 64'({2'b00, 1'b1, 1'b0, {BW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}});
                checkOutput($sformatf("inst%0d_reset_drive", k), actDrive, expDrive);
                expQ.delete();
                refLast  = 1'b1;
                refSweep = 0;
            end else if (refSweep < DEPTH) begin
                expDrive = 64'({2'b00, 1'b1, 1'b1, {BW{1'b1}}, AW'(refSweep), {DW{1'b0}}});
                checkOutput($sformatf("inst%0d_sweep_drive", k), actDrive, expDrive);
                refMem[refSweep] = '0;
                refSweep++;
            end else begin
                hasWin = m0_req || m1_req;
                if (m0_req && m1_req) win = FP ? 1'b0 : ~refLast;
                else                  win = m1_req;
                wWe = 1'b0; wBe = '0; wAd = '0; wWd = '0;
                if (hasWin) begin
                    wWe = win ? m1_we    : m0_we;
                    wBe = win ? m1_be    : m0_be;
                    wAd = win ? m1_addr  : m0_addr;
                    wWd = win ? m1_wdata : m0_wdata;
                end
                expDrive = 64'({hasWin && win, hasWin && !win, 1'b0, wWe, wBe, wAd, wWd});
                checkOutput($sformatf("inst%0d_run_drive", k), actDrive, expDrive);
                if (hasWin) begin
                    refLast = win;
                    if (wWe) begin
                        for (int b = 0; b < BW; b++) begin
                            if (wBe[b]) refMem[wAd][8*b +: 8] = wWd[8*b +: 8];
                        end
                    end else begin
                        expQ.push_back('{owner: win, data: refMem[wAd], due: cyc + 1});
                    end
                end
            end
        end

        resp_t e;
        // Monitor: pops an expected response whenever a response shows up or one is overdue.
        always @(negedge clk) begin
            #1;
            if (rv0 || rv1 || (expQ.size() > 0 && expQ[0].due <= cyc)) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("inst%0d_unexpected_rvalid", k), 64'({rv1, rv0}), 64'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("inst%0d_read_resp", k),
                                64'({16'(cyc), rv1, rv0, (e.owner ? rd1 : rd0)}),
                                64'({16'(e.due), e.owner, !e.owner, e.data}));
                end
            end
        end
    end

    task automatic applyStimulus(input int who, input logic req, input logic we, input logic [BW-1:0] be,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (who == 0) begin
            m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic stepSample(output logic g0Both, output logic g1Both);
        @(negedge clk);
        g0Both = gnt0[0] && gnt0[1];
        g1Both = gnt1[0] && gnt1[1];
        @(posedge clk);
        #1;
    endtask

    task automatic holdUntilGranted(input int who, input int budget);
        logic g0, g1, got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            stepSample(g0, g1);
            got = (who == 0) ? g0 : g1;
        end
        checkOutput($sformatf("m%0d_grant_wait", who), 64'(got), 64'(1));
        applyStimulus(who, 1'b0, 1'b0, '0, '0, '0);
    endtask

    logic g0, g1;

    initial begin
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] sweep with m0 read pending");
        reset = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 12'h123, '0);
        holdUntilGranted(0, DEPTH + 8);

        $display("[TB] write then read");
        applyStimulus(0, 1'b1, 1'b1, 4'hF, 12'h123, 32'hDEADBEEF);
        holdUntilGranted(0, 4);
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 12'h123, '0);
        holdUntilGranted(0, 4);

        $display("[TB] byte enables");
        applyStimulus(0, 1'b1, 1'b1, 4'hF, 12'h005, 32'h11223344);
        holdUntilGranted(0, 4);
        applyStimulus(0, 1'b1, 1'b1, 4'b0101, 12'h005, 32'hAABBCCDD);
        holdUntilGranted(0, 4);
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 12'h005, '0);
        holdUntilGranted(0, 4);

        $display("[TB] contention");
        applyStimulus(0, 1'b1, 1'b1, 4'hF, 12'h010, 32'h01010101);
        holdUntilGranted(0, 4);
        applyStimulus(1, 1'b1, 1'b1, 4'hF, 12'h020, 32'h02020202);
        holdUntilGranted(1, 4);
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 12'h010, '0);
        applyStimulus(1, 1'b1, 1'b0, 4'h0, 12'h020, '0);
        repeat (8) stepSample(g0, g1);
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) stepSample(g0, g1);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        stepSample(g0, g1);

        $display("[TB] random traffic");
        g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (m0_req && !g0) begin
                if ($urandom_range(3) == 0) m0_req = 1'b0;
            end else begin
                applyStimulus(0, ($urandom_range(2) != 0), 1'($urandom_range(1)), 4'($urandom),
                              12'($urandom_range(15)), $urandom);
            end
            if (m1_req && !g1) begin
                if ($urandom_range(3) == 0) m1_req = 1'b0;
            end else begin
                applyStimulus(1, ($urandom_range(2) != 0), 1'($urandom_range(1)), 4'($urandom),
                              12'($urandom_range(15)), $urandom);
            end
            stepSample(g0, g1);
        end
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) stepSample(g0, g1);

        $display("[TB] reset during read");
        applyStimulus(1, 1'b1, 1'b0, 4'h0, 12'h020, '0);
        stepSample(g0, g1);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        repeat (2) stepSample(g0, g1);
        reset = 1'b0;
        repeat (DEPTH + 2) stepSample(g0, g1);
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 12'h123, '0);
        holdUntilGranted(0, 4);
        repeat (3) stepSample(g0, g1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
